// File: rtl/sodor_mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one single-port memory, one outstanding transaction.
// Optional perf counters enabled with the SODOR_MEM_ARB_PERF_EN macro.
module sodor_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_valid,
    output logic              imem_req_ready,
    input  logic [ADDR_W-1:0] imem_req_addr,
    output logic              imem_resp_valid,
    output logic [DATA_W-1:0] imem_resp_data,
    input  logic              dmem_req_valid,
    output logic              dmem_req_ready,
    input  logic [ADDR_W-1:0] dmem_req_addr,
    input  logic [DATA_W-1:0] dmem_req_data,
    input  logic              dmem_req_write_en,
    output logic              dmem_resp_valid,
    output logic [DATA_W-1:0] dmem_resp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic              mem_req_write_en,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              err_spurious
`ifdef SODOR_MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_imem_stall,
    output logic [31:0]       perf_dmem_stall,
    output logic [31:0]       perf_xact
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

    state_t            state_r;
    logic              owner_dmem_r;
    logic [3:0]        starve_cnt_r;
    logic              mem_req_valid_r;
    logic [ADDR_W-1:0] mem_req_addr_r;
    logic [DATA_W-1:0] mem_req_data_r;
    logic              mem_req_write_en_r;
    logic              imem_resp_valid_r;
    logic [DATA_W-1:0] imem_resp_data_r;
    logic              dmem_resp_valid_r;
    logic [DATA_W-1:0] dmem_resp_data_r;
    logic              err_spurious_r;

    logic              grant_dmem_s;
    logic              grant_imem_s;
    logic              imem_ready_s;
    logic              dmem_ready_s;

    // Arbitration: dmem has priority unless imem has lost STARVE_LIMIT times in a row.
    always_comb begin
        grant_dmem_s = 1'b0;
        grant_imem_s = 1'b0;
        if (dmem_req_valid && !(imem_req_valid && (starve_cnt_r == STARVE_MAX))) begin
            grant_dmem_s = 1'b1;
        end else begin
            grant_imem_s = imem_req_valid;
        end
        imem_ready_s = (state_r == ST_IDLE) && grant_imem_s;
        dmem_ready_s = (state_r == ST_IDLE) && grant_dmem_s;
    end

    // Main transaction FSM with latched request fields and response routing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r            <= ST_IDLE;
            owner_dmem_r       <= 1'b0;
            starve_cnt_r       <= 4'd0;
            mem_req_valid_r    <= 1'b0;
            mem_req_addr_r     <= {ADDR_W{1'b0}};
            mem_req_data_r     <= {DATA_W{1'b0}};
            mem_req_write_en_r <= 1'b0;
            imem_resp_valid_r  <= 1'b0;
            imem_resp_data_r   <= {DATA_W{1'b0}};
            dmem_resp_valid_r  <= 1'b0;
            dmem_resp_data_r   <= {DATA_W{1'b0}};
            err_spurious_r     <= 1'b0;
        end else begin
            if (mem_resp_valid && (state_r != ST_WAIT)) begin
                err_spurious_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (dmem_ready_s) begin
                        state_r            <= ST_ISSUE;
                        mem_req_valid_r    <= 1'b1;
                        owner_dmem_r       <= 1'b1;
                        mem_req_addr_r     <= dmem_req_addr;
                        mem_req_data_r     <= dmem_req_data;
                        mem_req_write_en_r <= dmem_req_write_en;
                        if (imem_req_valid && (starve_cnt_r != STARVE_MAX)) begin
                            starve_cnt_r <= starve_cnt_r + 4'd1;
                        end
                    end else if (imem_ready_s) begin
                        state_r            <= ST_ISSUE;
                        mem_req_valid_r    <= 1'b1;
                        owner_dmem_r       <= 1'b0;
                        mem_req_addr_r     <= imem_req_addr;
                        mem_req_data_r     <= {DATA_W{1'b0}};
                        mem_req_write_en_r <= 1'b0;
                        starve_cnt_r       <= 4'd0;
                    end
                end
                ST_ISSUE: begin
                    mem_req_valid_r <= 1'b0;
                    state_r         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state_r <= ST_RESP;
                        if (owner_dmem_r) begin
                            dmem_resp_valid_r <= 1'b1;
                            dmem_resp_data_r  <= mem_resp_data;
                        end else begin
                            imem_resp_valid_r <= 1'b1;
                            imem_resp_data_r  <= mem_resp_data;
                        end
                    end
                end
                ST_RESP: begin
                    imem_resp_valid_r <= 1'b0;
                    dmem_resp_valid_r <= 1'b0;
                    state_r           <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SODOR_MEM_ARB_PERF_EN
    logic [31:0] perf_imem_stall_r;
    logic [31:0] perf_dmem_stall_r;
    logic [31:0] perf_xact_r;

    // Free-running wrap-around stall and completion counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_imem_stall_r <= 32'd0;
            perf_dmem_stall_r <= 32'd0;
            perf_xact_r       <= 32'd0;
        end else begin
            if (imem_req_valid && !imem_ready_s) begin
                perf_imem_stall_r <= perf_imem_stall_r + 32'd1;
            end
            if (dmem_req_valid && !dmem_ready_s) begin
                perf_dmem_stall_r <= perf_dmem_stall_r + 32'd1;
            end
            if (state_r == ST_RESP) begin
                perf_xact_r <= perf_xact_r + 32'd1;
            end
        end
    end

    assign perf_imem_stall = perf_imem_stall_r;
    assign perf_dmem_stall = perf_dmem_stall_r;
    assign perf_xact       = perf_xact_r;
`endif

    assign imem_req_ready   = imem_ready_s;
    assign dmem_req_ready   = dmem_ready_s;
    assign mem_req_valid    = mem_req_valid_r;
    assign mem_req_addr     = mem_req_addr_r;
    assign mem_req_data     = mem_req_data_r;
    assign mem_req_write_en = mem_req_write_en_r;
    assign imem_resp_valid  = imem_resp_valid_r;
    assign imem_resp_data   = imem_resp_data_r;
    assign dmem_resp_valid  = dmem_resp_valid_r;
    assign dmem_resp_data   = dmem_resp_data_r;
    assign err_spurious     = err_spurious_r;

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Directed bench for sodor_mem_arbiter: fetch, store, contention, back-pressure, spurious and reset.
module tb_sodor_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_data;
    logic        dmem_req_write_en;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_req_write_en;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        err_spurious;
`ifdef SODOR_MEM_ARB_PERF_EN
    logic [31:0] perf_imem_stall;
    logic [31:0] perf_dmem_stall;
    logic [31:0] perf_xact;
    logic [31:0] snap_stall;
    logic [31:0] snap_xact;
`endif

    int checks = 0;
    int errors = 0;
    logic exp_i;

    always #5 clk = ~clk;

    sodor_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_data(dmem_req_data),
        .dmem_req_write_en(dmem_req_write_en), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data(dmem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_write_en(mem_req_write_en),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .err_spurious(err_spurious)
`ifdef SODOR_MEM_ARB_PERF_EN
        ,
        .perf_imem_stall(perf_imem_stall), .perf_dmem_stall(perf_dmem_stall),
        .perf_xact(perf_xact)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        imem_req_valid = 1'b0; imem_req_addr = 32'h0;
        dmem_req_valid = 1'b0; dmem_req_addr = 32'h0; dmem_req_data = 32'h0;
        dmem_req_write_en = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        tick();
        chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_iresp", {31'd0, imem_resp_valid}, 32'd0);
        chk("rst_dresp", {31'd0, dmem_resp_valid}, 32'd0);
        chk("rst_err", {31'd0, err_spurious}, 32'd0);
        chk("rst_addr", mem_req_addr, 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch, L=1
        imem_req_valid = 1'b1; imem_req_addr = 32'h100;
        #1;
        chk("f_iready", {31'd0, imem_req_ready}, 32'd1);
        chk("f_dready", {31'd0, dmem_req_ready}, 32'd0);
        tick();
        imem_req_valid = 1'b0; imem_req_addr = 32'hFFF;
        chk("f_mvalid", {31'd0, mem_req_valid}, 32'd1);
        chk("f_maddr", mem_req_addr, 32'h100);
        chk("f_mwe", {31'd0, mem_req_write_en}, 32'd0);
        tick();
        chk("f_mvalid_1cyc", {31'd0, mem_req_valid}, 32'd0);
        chk("f_addr_hold", mem_req_addr, 32'h100);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0;
        chk("f_iresp", {31'd0, imem_resp_valid}, 32'd1);
        chk("f_idata", imem_resp_data, 32'hDEADBEEF);
        chk("f_dresp", {31'd0, dmem_resp_valid}, 32'd0);
        tick();
        chk("f_iresp_1cyc", {31'd0, imem_resp_valid}, 32'd0);
        chk("f_idata_hold", imem_resp_data, 32'hDEADBEEF);

        // Store, L=3
        dmem_req_valid = 1'b1; dmem_req_addr = 32'h200; dmem_req_data = 32'h12345678;
        dmem_req_write_en = 1'b1;
        #1;
        chk("s_dready", {31'd0, dmem_req_ready}, 32'd1);
        tick();
        dmem_req_valid = 1'b0; dmem_req_write_en = 1'b0; dmem_req_data = 32'h0;
        chk("s_mvalid", {31'd0, mem_req_valid}, 32'd1);
        chk("s_maddr", mem_req_addr, 32'h200);
        chk("s_mwe", {31'd0, mem_req_write_en}, 32'd1);
        chk("s_mdata", mem_req_data, 32'h12345678);
        tick();
        chk("s_dresp_t2", {31'd0, dmem_resp_valid}, 32'd0);
        chk("s_mdata_hold", mem_req_data, 32'h12345678);
        tick();
        chk("s_dresp_t3", {31'd0, dmem_resp_valid}, 32'd0);
        tick();
        chk("s_dresp_t4", {31'd0, dmem_resp_valid}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hA5A5A5A5;
        tick();
        mem_resp_valid = 1'b0;
        chk("s_dresp_t5", {31'd0, dmem_resp_valid}, 32'd1);
        chk("s_ddata", dmem_resp_data, 32'hA5A5A5A5);
        chk("s_iresp", {31'd0, imem_resp_valid}, 32'd0);
        tick();
        chk("s_dresp_1cyc", {31'd0, dmem_resp_valid}, 32'd0);

        // Contention: expected grant order D,D,D,D,I repeating
        imem_req_valid = 1'b1; imem_req_addr = 32'h400;
        dmem_req_valid = 1'b1; dmem_req_addr = 32'h500; dmem_req_write_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_i = ((k % 5) == 4);
            #1;
            chk("c_iready", {31'd0, imem_req_ready}, {31'd0, exp_i});
            chk("c_dready", {31'd0, dmem_req_ready}, {31'd0, ~exp_i});
            tick();
            chk("c_maddr", mem_req_addr, exp_i ? 32'h400 : 32'h500);
            tick();
            mem_resp_valid = 1'b1; mem_resp_data = 32'(k);
            tick();
            mem_resp_valid = 1'b0;
            chk("c_resp_owner", {31'd0, imem_resp_valid}, {31'd0, exp_i});
            tick();
        end
        imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
        tick();

        // Back-pressure: imem held during a dmem load
        dmem_req_valid = 1'b1; dmem_req_addr = 32'h300;
        imem_req_valid = 1'b1; imem_req_addr = 32'h104;
`ifdef SODOR_MEM_ARB_PERF_EN
        snap_stall = perf_imem_stall; snap_xact = perf_xact;
`endif
        #1;
        chk("b_dready", {31'd0, dmem_req_ready}, 32'd1);
        chk("b_iready_idle", {31'd0, imem_req_ready}, 32'd0);
        tick();
        dmem_req_valid = 1'b0;
        #1;
        chk("b_iready_issue", {31'd0, imem_req_ready}, 32'd0);
        tick();
        chk("b_iready_wait", {31'd0, imem_req_ready}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h33333333;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("b_iready_resp", {31'd0, imem_req_ready}, 32'd0);
        chk("b_dresp", {31'd0, dmem_resp_valid}, 32'd1);
        chk("b_ddata", dmem_resp_data, 32'h33333333);
        tick();
        chk("b_iready_after", {31'd0, imem_req_ready}, 32'd1);
        tick();
        imem_req_valid = 1'b0;
        chk("b_maddr", mem_req_addr, 32'h104);
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h44444444;
        tick();
        mem_resp_valid = 1'b0;
        chk("b_iresp", {31'd0, imem_resp_valid}, 32'd1);
        chk("b_idata", imem_resp_data, 32'h44444444);
        tick();
`ifdef SODOR_MEM_ARB_PERF_EN
        chk("p_istall", perf_imem_stall - snap_stall, 32'd4);
        chk("p_xact", perf_xact - snap_xact, 32'd2);
`endif

        // Spurious response in IDLE
        chk("sp_err_before", {31'd0, err_spurious}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h55555555;
        tick();
        mem_resp_valid = 1'b0;
        chk("sp_err", {31'd0, err_spurious}, 32'd1);
        chk("sp_iresp", {31'd0, imem_resp_valid}, 32'd0);
        chk("sp_dresp", {31'd0, dmem_resp_valid}, 32'd0);
        tick();
        tick();
        chk("sp_err_sticky", {31'd0, err_spurious}, 32'd1);

        // Reset during WAIT
        imem_req_valid = 1'b1; imem_req_addr = 32'h108;
        tick();
        imem_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("r_err", {31'd0, err_spurious}, 32'd0);
        chk("r_mvalid", {31'd0, mem_req_valid}, 32'd0);
        chk("r_maddr", mem_req_addr, 32'd0);
        chk("r_idata", imem_resp_data, 32'd0);
        chk("r_ddata", dmem_resp_data, 32'd0);
`ifdef SODOR_MEM_ARB_PERF_EN
        chk("r_perf_xact", perf_xact, 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h66666666;
        tick();
        mem_resp_valid = 1'b0;
        chk("r_late_err", {31'd0, err_spurious}, 32'd1);
        chk("r_late_iresp", {31'd0, imem_resp_valid}, 32'd0);
        chk("r_late_dresp", {31'd0, dmem_resp_valid}, 32'd0);
        tick();
        chk("r_late_iresp2", {31'd0, imem_resp_valid}, 32'd0);
        imem_req_valid = 1'b1;
        #1;
        chk("r_idle_ready", {31'd0, imem_req_ready}, 32'd1);
        imem_req_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
